sha256_padder: RTL



---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_padder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

    localparam int unsigned SHA256_BLOCK_BYTES = 64;
    localparam int unsigned SHA256_LEN_BYTES   = 8;
    localparam int unsigned SHA256_LEN_POS     = 56;
    localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPass,
        StPad80,
        StZero,
        StLen
    } padder_state_e;

endpackage

// File: rtl/sha256_padder.sv
// Streaming SHA-256 padder: passes message bytes through, then appends 0x80,
// zero fill and the 64-bit big-endian bit length so the output fills whole blocks.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       msg_empty,
    input  logic [7:0] msg_data,
    input  logic       msg_valid,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic       out_start,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       len_ovf
);

    localparam logic [5:0] LEN_POS = 6'(SHA256_LEN_POS);

    padder_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] raw_q;
    logic [2:0]       len_idx_q;
    logic             empty_q;
    logic             len_ovf_q;
    logic [5:0]       pos;
    logic [5:0]       pos_inc;
    logic [63:0]      len_bits;
    logic [5:0]       len_sh;
    logic [7:0]       len_byte;

    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign pos     = cnt_q[5:0];
    assign pos_inc = cnt_inc[5:0];

    // ~len_idx == 7 - len_idx, so index 0 selects the most significant byte.
    assign len_bits = 64'(raw_q) << 3;
    assign len_sh   = {~len_idx_q, 3'b000};
    assign len_byte = 8'(len_bits >> len_sh);

    assign busy    = (state_q != StIdle);
    assign len_ovf = len_ovf_q;

    always_comb begin
        msg_ready = 1'b0;
        out_start = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            StStart: out_start = 1'b1;
            StPass: begin
                out_data  = msg_data;
                out_valid = msg_valid;
                msg_ready = out_ready;
            end
            StPad80: begin
                out_data  = SHA256_PAD_BYTE;
                out_valid = 1'b1;
            end
            // Landing exactly on the length position emits no zero byte.
            StZero: out_valid = (pos != LEN_POS);
            StLen: begin
                out_data  = len_byte;
                out_valid = 1'b1;
                out_last  = (len_idx_q == 3'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            raw_q     <= '0;
            len_idx_q <= 3'd0;
            empty_q   <= 1'b0;
            len_ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q     <= '0;
                        len_idx_q <= 3'd0;
                        len_ovf_q <= 1'b0;
                        empty_q   <= msg_empty;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (empty_q) begin
                        raw_q   <= '0;
                        state_q <= StPad80;
                    end else begin
                        state_q <= StPass;
                    end
                end
                StPass: begin
                    if (msg_valid && out_ready) begin
                        cnt_q <= cnt_inc;
                        if (&cnt_q) begin
                            len_ovf_q <= 1'b1;
                        end
                        if (msg_last) begin
                            // Freeze the raw length before padding advances the counter.
                            raw_q   <= cnt_inc;
                            state_q <= StPad80;
                        end
                    end
                end
                StPad80: begin
                    if (out_ready) begin
                        cnt_q   <= cnt_inc;
                        state_q <= (pos_inc == LEN_POS) ? StLen : StZero;
                    end
                end
                StZero: begin
                    if (pos == LEN_POS) begin
                        state_q <= StLen;
                    end else if (out_ready) begin
                        cnt_q <= cnt_inc;
                        if (pos_inc == LEN_POS) begin
                            state_q <= StLen;
                        end
                    end
                end
                StLen: begin
                    if (out_ready) begin
                        len_idx_q <= len_idx_q + 3'd1;
                        if (len_idx_q == 3'd7) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
